// File: rtl/sequential_multiplier_n_if.sv
// sequential_multiplier_n_if: start/busy/done handshake and operand/result bus of the sequential multiplier
interface sequential_multiplier_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] product_low;
    logic [WIDTH-1:0] product_high;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  product_low, product_high, overflow, busy, done
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output product_low, product_high, overflow, busy, done
    );
endinterface

// File: rtl/sequential_multiplier_n.sv
// sequential_multiplier_n: shift-and-add multiplier with signed mode, early termination and overflow flag
module sequential_multiplier_n #(
    parameter int WIDTH      = 8,
    parameter int EARLY_TERM = 1
) (
    input logic                    clk,
    input logic                    reset,
    sequential_multiplier_n_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MULTIPLY, FIXUP, FINISH} state_t;

    state_t             state_q;
    logic [2*WIDTH-1:0] p_q, a_q, prod_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      count_q;
    logic               neg_q, sgn_q, ovf_q, busy_q, done_q;

    logic [WIDTH-1:0]   mag_a_d, mag_b_d;
    logic [2*WIDTH-1:0] sum_d, final_d;
    logic               last_d, ovf_d, neg_d;

    // Operand magnitudes, accumulate step, exit test and sign/overflow fixup
    always_comb begin
        mag_a_d = (bus.signed_mode & bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
        mag_b_d = (bus.signed_mode & bus.multiplier[WIDTH-1]) ? -bus.multiplier : bus.multiplier;
        neg_d   = bus.signed_mode & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
        sum_d   = b_q[0] ? p_q + a_q : p_q;
        last_d  = (count_q == CW'(WIDTH-1)) || ((EARLY_TERM != 0) && ((b_q >> 1) == '0));
        final_d = neg_q ? -p_q : p_q;
        ovf_d   = sgn_q ? (final_d[2*WIDTH-1:WIDTH] != {WIDTH{final_d[WIDTH-1]}})
                        : (final_d[2*WIDTH-1:WIDTH] != '0);
    end

    // Control FSM with datapath and registered outputs; result only published at FIXUP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        p_q     <= '0;
                        a_q     <= {{WIDTH{1'b0}}, mag_a_d};
                        b_q     <= mag_b_d;
                        neg_q   <= neg_d;
                        sgn_q   <= bus.signed_mode;
                        count_q <= '0;
                        prod_q  <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= MULTIPLY;
                    end
                end
                MULTIPLY: begin
                    p_q     <= sum_d;
                    a_q     <= a_q << 1;
                    b_q     <= b_q >> 1;
                    count_q <= count_q + CW'(1);
                    if (last_d) state_q <= FIXUP;
                end
                FIXUP: begin
                    p_q     <= final_d;
                    prod_q  <= final_d;
                    ovf_q   <= ovf_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= FINISH;
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.product_low  = prod_q[WIDTH-1:0];
    assign bus.product_high = prod_q[2*WIDTH-1:WIDTH];
    assign bus.overflow     = ovf_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_sequential_multiplier_n.sv
// tb_sequential_multiplier_n: directed and random checks of three multiplier configurations against an arithmetic model
module tb_sequential_multiplier_n;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   sel = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sequential_multiplier_n_if #(.WIDTH(8))  i0 ();
    sequential_multiplier_n_if #(.WIDTH(8))  i1 ();
    sequential_multiplier_n_if #(.WIDTH(16)) i2 ();

    sequential_multiplier_n #(.WIDTH(8),  .EARLY_TERM(0)) u0 (.clk(clk), .reset(reset), .bus(i0.slave));
    sequential_multiplier_n #(.WIDTH(8),  .EARLY_TERM(1)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));
    sequential_multiplier_n #(.WIDTH(16), .EARLY_TERM(1)) u2 (.clk(clk), .reset(reset), .bus(i2.slave));

    logic [31:0] prod_s;
    logic        ovf_s, busy_s, done_s;

    always_comb begin
        prod_s = sel == 0 ? {16'h0, i0.product_high, i0.product_low} :
                 sel == 1 ? {16'h0, i1.product_high, i1.product_low} :
                            {i2.product_high, i2.product_low};
        ovf_s  = sel == 0 ? i0.overflow : sel == 1 ? i1.overflow : i2.overflow;
        busy_s = sel == 0 ? i0.busy : sel == 1 ? i1.busy : i2.busy;
        done_s = sel == 0 ? i0.done : sel == 1 ? i1.done : i2.done;
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s sel=%0d observed=%0h expected=%0h", tag, sel, o, e);
        end
    endtask

    // Product as signed/unsigned integer arithmetic; k from bit-length of |multiplier|
    task automatic model(input int w, input bit et, input bit sm, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output bit ov, output int k);
        longint ua, ub, sa, sb, pr, mb;
        int bl;
        ua = longint'({48'h0, a}) & ((longint'(1) << w) - 1);
        ub = longint'({48'h0, b}) & ((longint'(1) << w) - 1);
        sa = (sm && ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (sm && ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        pr = sa * sb;
        p  = 32'(pr & ((longint'(1) << (2 * w)) - 1));
        ov = sm ? (pr < -(longint'(1) << (w - 1)) || pr >= (longint'(1) << (w - 1)))
                : (pr >= (longint'(1) << w));
        mb = sb < 0 ? -sb : sb;
        bl = 0;
        while (mb > 0) begin
            bl++;
            mb = mb >> 1;
        end
        k = et ? (bl < 1 ? 1 : bl) : w;
    endtask

    task automatic drive(input bit st, input bit sm, input logic [15:0] a, input logic [15:0] b);
        case (sel)
            0: begin i0.start = st; i0.signed_mode = sm; i0.multiplicand = a[7:0]; i0.multiplier = b[7:0]; end
            1: begin i1.start = st; i1.signed_mode = sm; i1.multiplicand = a[7:0]; i1.multiplier = b[7:0]; end
            default: begin i2.start = st; i2.signed_mode = sm; i2.multiplicand = a; i2.multiplier = b; end
        endcase
    endtask

    task automatic run(input bit sm, input logic [15:0] a, input logic [15:0] b, input bit hold, input bit poke);
        logic [31:0] ep;
        bit eo;
        int k, n, bc;
        model(sel == 2 ? 16 : 8, sel != 0, sm, a, b, ep, eo, k);
        @(negedge clk);
        drive(1'b1, sm, a, b);
        @(posedge clk);
        #1;
        if (!hold) drive(1'b0, sm, a, b);
        chk("accept_busy", busy_s, 1);
        chk("accept_prod", prod_s, 0);
        chk("accept_ovf", ovf_s, 0);
        n = 0;
        bc = 1;
        while (!done_s && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (busy_s) bc++;
            if (poke && n == 2) drive(1'b1, ~sm, ~a, ~b);
            if (poke && n == 3) drive(1'b0, sm, a, b);
        end
        chk("done_edge", n, k + 1);
        chk("busy_cycles", bc, k + 1);
        chk("product", prod_s, ep);
        chk("overflow", ovf_s, eo);
        @(posedge clk);
        #1;
        chk("done_single", done_s, 0);
        chk("idle_busy", busy_s, 0);
        chk("held_product", prod_s, ep);
    endtask

    initial begin
        int nd;
        bit sm;
        logic [15:0] a, b;
        i0.start = 0; i0.signed_mode = 0; i0.multiplicand = 0; i0.multiplier = 0;
        i1.start = 0; i1.signed_mode = 0; i1.multiplicand = 0; i1.multiplier = 0;
        i2.start = 0; i2.signed_mode = 0; i2.multiplicand = 0; i2.multiplier = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            chk("rst_prod", prod_s, 0);
            chk("rst_ovf", ovf_s, 0);
            chk("rst_busy", busy_s, 0);
            chk("rst_done", done_s, 0);
        end
        @(negedge clk);
        reset = 1'b0;

        sel = 0;
        run(0, 16'hFF, 16'hFF, 0, 0);
        chk("ff_x_ff", prod_s, 32'hFE01);
        chk("ff_x_ff_ovf", ovf_s, 1);

        sel = 1;
        run(1, 16'hFD, 16'h05, 0, 0);
        chk("m3_x_5", prod_s, 32'hFFF1);
        run(1, 16'h80, 16'h80, 0, 0);
        chk("80_x_80", prod_s, 32'h4000);
        chk("80_x_80_ovf", ovf_s, 1);
        run(1, 16'h80, 16'h01, 0, 0);
        chk("80_x_01", prod_s, 32'hFF80);
        run(0, 16'h37, 16'h00, 0, 0);
        chk("37_x_00", prod_s, 32'h0000);
        run(0, 16'h37, 16'h01, 0, 0);
        chk("37_x_01", prod_s, 32'h0037);

        sel = 2;
        run(0, 16'h1234, 16'h5678, 0, 0);
        chk("w16_u", prod_s, 32'h06260060);
        run(1, 16'h1234, 16'h5678, 0, 0);
        chk("w16_s", prod_s, 32'h06260060);
        chk("w16_s_ovf", ovf_s, 1);

        sel = 0;
        run(0, 16'h6B, 16'hA5, 0, 1);
        run(1, 16'hC8, 16'h13, 1, 0);
        run(1, 16'h7F, 16'h81, 0, 0);
        sel = 1;
        run(0, 16'h11, 16'h03, 1, 0);
        run(0, 16'hE0, 16'h40, 0, 0);

        sel = 0;
        @(negedge clk);
        drive(1'b1, 0, 16'h5A, 16'hC3);
        @(posedge clk);
        #1;
        drive(1'b0, 0, 16'h5A, 16'hC3);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy_s, 1'b0);
        chk("abort_done", done_s, 1'b0);
        chk("abort_prod", prod_s, 0);
        chk("abort_ovf", ovf_s, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_s || busy_s) nd++;
        end
        chk("abort_quiet", nd, 0);
        run(0, 16'h5A, 16'hC3, 0, 0);

        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 2));
            sm = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 3));
            run(sm, a, b, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
